rom_boot_copier: RTL



---
 rtl/rom_boot_copier_pkg.sv | 31 +++
 rtl/rom_boot_copier_word_addr_counter.sv | 32 +++
 rtl/rom_boot_copier.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/rom_boot_copier_pkg.sv
// Shared definitions for the ROM boot copier: FSM state encodings, the
// header length field bounds and the length clamp helper.
package boot_copier_defs;

  // FSM state encodings (3-bit, legacy-compatible constants)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_COPY  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Word-count field inside the header word
  localparam int LEN_MSB = 15;
  localparam int LEN_LSB = 0;

  // Byte distance between consecutive 32-bit words
  localparam logic [15:0] WORD_STEP = 16'd4;

  // Limit a raw header word count to the configured maximum payload
  function automatic logic [15:0] clamp_len(input logic [15:0] raw,
                                            input logic [15:0] max_words);
    logic [15:0] result;
    if (raw > max_words) begin
      result = max_words;
    end else begin
      result = raw;
    end
    return result;
  endfunction

endpackage

// File: rtl/rom_boot_copier_word_addr_counter.sv
// Loadable 16-bit byte-address counter stepping by one 32-bit word,
// with a companion word index counting steps since the last load.
// Address arithmetic wraps modulo 2^16.
module word_addr_counter
  import boot_copier_defs::*;
#(
  parameter logic [15:0] RESET_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_addr,
  input  logic        step,
  output logic [15:0] addr,
  output logic [15:0] index
);

  // Address/index register: load wins over step, reset wins over both
  always_ff @(posedge clk) begin
    if (reset) begin
      addr  <= RESET_ADDR;
      index <= 16'd0;
    end else if (load) begin
      addr  <= load_addr;
      index <= 16'd0;
    end else if (step) begin
      addr  <= addr + WORD_STEP;
      index <= index + 16'd1;
    end
  end

endmodule

// File: rtl/rom_boot_copier.sv
// Boot image copier: reads a length header from boot ROM, streams the
// payload words into data RAM at one word per cycle, then releases the
// CPU from reset. All outputs come straight from flops.
module rom_boot_copier
  import boot_copier_defs::*;
#(
  parameter logic [15:0] SRC_BASE  = 16'h0040,
  parameter logic [15:0] DST_BASE  = 16'h0000,
  parameter logic [15:0] MAX_WORDS = 16'd1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] rom_address,
  input  logic [31:0] rom_data,
  output logic [15:0] ram_address,
  output logic [31:0] ram_data,
  output logic        ram_write,
  output logic        busy,
  output logic        done,
  output logic        clamped,
  output logic        cpu_hold
);

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [15:0] len;
  logic [15:0] hdr_len;
  logic [15:0] hdr_len_clamped;
  logic        take_start;
  logic        last_word;
  logic        write_ok;

  logic        src_load;
  logic [15:0] src_load_addr;
  logic        src_step;
  logic [15:0] src_addr;
  logic [15:0] src_index;

  logic        dst_load;
  logic        dst_step;
  logic [15:0] dst_addr;
  logic [15:0] dst_index;

  assign hdr_len         = rom_data[LEN_MSB:LEN_LSB];
  assign hdr_len_clamped = clamp_len(hdr_len, MAX_WORDS);
  assign take_start      = start && ((state == ST_IDLE) || (state == ST_DONE));
  // src_index counts words fetched in COPY; the last fetch ends the burst
  assign last_word       = (src_index == (len - 16'd1));
  // dst_index counts words written; never write past the latched length
  assign write_ok        = (dst_index < len);

  // The source counter register is the registered ROM address
  assign rom_address = src_addr;

  // ROM read pointer: header address on start, first payload word after HDR
  word_addr_counter #(
    .RESET_ADDR (SRC_BASE)
  ) u_src_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (src_load),
    .load_addr (src_load_addr),
    .step      (src_step),
    .addr      (src_addr),
    .index     (src_index)
  );

  // RAM write pointer: restarts at DST_BASE for every copy
  word_addr_counter #(
    .RESET_ADDR (DST_BASE)
  ) u_dst_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (dst_load),
    .load_addr (DST_BASE),
    .step      (dst_step),
    .addr      (dst_addr),
    .index     (dst_index)
  );

  // Counter control decoded from the current state
  always_comb begin
    src_load      = 1'b0;
    src_load_addr = SRC_BASE;
    src_step      = 1'b0;
    dst_load      = 1'b0;
    dst_step      = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (take_start) begin
          src_load      = 1'b1;
          src_load_addr = SRC_BASE;
        end else begin
          src_load      = 1'b0;
        end
      end
      ST_HDR: begin
        dst_load = 1'b1;
        if (hdr_len_clamped != 16'd0) begin
          src_load      = 1'b1;
          src_load_addr = SRC_BASE + WORD_STEP;
        end else begin
          src_load      = 1'b0;
        end
      end
      ST_COPY: begin
        src_step = 1'b1;
        dst_step = 1'b1;
      end
      default: begin
        src_load = 1'b0;
        dst_load = 1'b0;
      end
    endcase
  end

  // Next-state decode; start is only honoured when idle or finished
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_HDR;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (hdr_len_clamped == 16'd0) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_COPY;
        end
      end
      ST_COPY: begin
        if (last_word) begin
          state_next = ST_DRAIN;
        end else begin
          state_next = ST_COPY;
        end
      end
      ST_DRAIN: begin
        state_next = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          state_next = ST_HDR;
        end else begin
          state_next = ST_DONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register and busy flag (busy tracks HDR/COPY of the new state)
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ST_HDR) || (state_next == ST_COPY);
    end
  end

  // Latched payload length and the sticky clamp flag
  always_ff @(posedge clk) begin
    if (reset) begin
      len     <= 16'd0;
      clamped <= 1'b0;
    end else if (state == ST_HDR) begin
      len <= hdr_len_clamped;
      if (hdr_len > MAX_WORDS) begin
        clamped <= 1'b1;
      end
    end else if (take_start) begin
      clamped <= 1'b0;
    end
  end

  // RAM write port: one strobe per COPY cycle, dropped at the DRAIN exit
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_address <= DST_BASE;
      ram_data    <= 32'd0;
      ram_write   <= 1'b0;
    end else if (state == ST_COPY) begin
      ram_address <= dst_addr;
      ram_data    <= rom_data;
      ram_write   <= write_ok;
    end else begin
      ram_write   <= 1'b0;
    end
  end

  // Completion flag and CPU hold: done is cleared by a new start,
  // cpu_hold only returns high through reset
  always_ff @(posedge clk) begin
    if (reset) begin
      done     <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      if (take_start) begin
        done <= 1'b0;
      end else if (state == ST_DONE) begin
        done <= 1'b1;
      end
      if (state == ST_DONE) begin
        cpu_hold <= 1'b0;
      end
    end
  end

endmodule
